// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if : IF / LS request ports and shared memory port of the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [DATA_W-1:0]     o_if_rdata;

  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [DATA_W/8-1:0]   i_ls_be;
  logic [ADDR_W-1:0]     i_ls_addr;
  logic [DATA_W-1:0]     i_ls_wdata;
  logic                  o_ls_gnt;
  logic                  o_ls_rvalid;
  logic [DATA_W-1:0]     o_ls_rdata;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [DATA_W/8-1:0]   o_mem_be;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [DATA_W-1:0]     i_mem_rdata;

  logic                  o_busy;

  // The arbiter itself sits on the slave side.
  modport slave (
    input  i_if_req, i_if_addr,
    input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : single-outstanding IF/LS arbiter, LS priority with IF starvation guard
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  wire              i_clk,
  input  wire              i_rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] c_lim = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_ls_q, owner_ls_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic              if_wins, ls_wins, sel_ls;
  logic              mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign if_wins = bus.i_if_req && (!bus.i_ls_req || (starve_q == c_lim));
  assign ls_wins = bus.i_ls_req && !if_wins;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    starve_d   = starve_q;
    sel_ls     = owner_ls_q;
    mem_req    = 1'b0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_if_req || bus.i_ls_req) begin
          mem_req    = 1'b1;
          sel_ls     = ls_wins;
          owner_ls_d = ls_wins;
          // Only an LS win over a waiting IF counts as a loss; saturate at the limit.
          if (ls_wins && bus.i_if_req)
            starve_d = (starve_q == c_lim) ? starve_q : starve_q + CNT_W'(1);
          else
            starve_d = '0;
          if (bus.i_mem_gnt) begin
            if_gnt  = !ls_wins;
            ls_gnt  = ls_wins;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (bus.i_mem_gnt) begin
          if_gnt  = !owner_ls_q;
          ls_gnt  = owner_ls_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_mem_rvalid) begin
          if_rvalid = !owner_ls_q;
          ls_rvalid = owner_ls_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory payload is zero whenever no request is presented.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = {BE_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (mem_req) begin
      if (sel_ls) begin
        mem_we    = bus.i_ls_we;
        mem_be    = bus.i_ls_be;
        mem_addr  = bus.i_ls_addr;
        mem_wdata = bus.i_ls_wdata;
      end else begin
        mem_be    = {BE_W{1'b1}};
        mem_addr  = bus.i_if_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_be    = mem_be;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_ls_gnt    = ls_gnt;
  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_ls_rvalid = ls_rvalid;
  assign bus.o_if_rdata  = bus.i_mem_rdata;
  assign bus.o_ls_rdata  = bus.i_mem_rdata;
  assign bus.o_busy      = (state_q != IDLE);

endmodule
`default_nettype wire
